// File: rtl/note_player_pkg.sv
// Shared types and sizing helpers for the note player.
// Imported by the top level and the tone generator.
package note_player_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/note_tone_gen.sv
// Square-wave generator: toggles every hp enabled cycles, starting high.
// Output is combinational from its own flops and en, so dropping en silences it at once.
module note_tone_gen
    import note_player_pkg::*;
#(
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [PERIOD_W-1:0] hp,
    output logic                audio
);

    logic [PERIOD_W-1:0] phase_q;
    logic                low_q;

    // Phase counter wraps at hp-1 and flips the half-cycle flag; held clear while disabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q <= '0;
            low_q   <= 1'b0;
        end else if (!en || hp == '0) begin
            phase_q <= '0;
            low_q   <= 1'b0;
        end else if (phase_q == hp - PERIOD_W'(1)) begin
            phase_q <= '0;
            low_q   <= ~low_q;
        end else begin
            phase_q <= phase_q + PERIOD_W'(1);
        end
    end

    assign audio = en && (hp != '0) && !low_q;

endmodule

// File: rtl/note_player.sv
// Plays one handshaked note as a square wave for dur*TICK_DIV cycles,
// then a fixed silent gap, then a one-cycle done pulse.
module note_player
    import note_player_pkg::*;
#(
    parameter int PERIOD_W   = 16,
    parameter int DUR_W      = 16,
    parameter int TICK_DIV   = 1000,
    parameter int GAP_CYCLES = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                note_val,
    output logic                note_rdy,
    input  logic [PERIOD_W-1:0] note_half_period,
    input  logic [DUR_W-1:0]    note_dur,
    input  logic                stop,
    output logic                audio_out,
    output logic                busy,
    output logic                done
);

    localparam int TICK_W = cnt_w(TICK_DIV);
    localparam int GAP_W  = cnt_w(GAP_CYCLES + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t              state_q, state_d;
    logic [PERIOD_W-1:0] hp_q, hp_d;
    logic [DUR_W-1:0]    rem_q, rem_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic                tick_fire;

    assign tick_fire = (tick_q == TICK_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            hp_q    <= '0;
            rem_q   <= '0;
            tick_q  <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            hp_q    <= hp_d;
            rem_q   <= rem_d;
            tick_q  <= tick_d;
            gap_q   <= gap_d;
        end
    end

    // Next-state logic; stop is checked first so it beats a coincident tick or end of note.
    always_comb begin
        state_d  = state_q;
        hp_d     = hp_q;
        rem_d    = rem_q;
        tick_d   = tick_q;
        gap_d    = gap_q;
        note_rdy = (state_q == IDLE) && !stop;
        busy     = (state_q == PLAY) || (state_q == GAP);
        done     = (state_q == DONE);

        case (state_q)
            IDLE: begin
                if (note_val && note_rdy) begin
                    hp_d   = note_half_period;
                    rem_d  = note_dur;
                    tick_d = '0;
                    gap_d  = '0;
                    if (note_dur != '0)
                        state_d = PLAY;
                    else if (GAP_CYCLES > 0)
                        state_d = GAP;
                    else
                        state_d = DONE;
                end
            end
            PLAY: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (tick_fire) begin
                    tick_d = '0;
                    rem_d  = rem_q - DUR_W'(1);
                    if (rem_q == DUR_W'(1)) begin
                        gap_d = '0;
                        if (GAP_CYCLES > 0)
                            state_d = GAP;
                        else
                            state_d = DONE;
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            GAP: begin
                if (stop)
                    state_d = IDLE;
                else if (gap_q == GAP_LAST)
                    state_d = DONE;
                else
                    gap_d = gap_q + GAP_W'(1);
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    note_tone_gen #(
        .PERIOD_W (PERIOD_W)
    ) u_tone (
        .clk   (clk),
        .rst   (rst),
        .en    (state_q == PLAY),
        .hp    (hp_q),
        .audio (audio_out)
    );

endmodule

// File: tb/tb_note_player.sv
// Scoreboard bench for note_player: stimulus queues the expected per-cycle trace,
// a monitor pops one entry for every cycle the DUT is busy or pulsing done.
module tb_note_player;

    localparam int PERIOD_W   = 8;
    localparam int DUR_W      = 8;
    localparam int TICK_DIV   = 4;
    localparam int GAP_CYCLES = 2;

    typedef struct packed {
        logic audio;
        logic busy;
        logic done;
        logic rdy;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                note_val;
    logic                note_rdy;
    logic [PERIOD_W-1:0] note_half_period;
    logic [DUR_W-1:0]    note_dur;
    logic                stop;
    logic                audio_out;
    logic                busy;
    logic                done;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    note_player #(
        .PERIOD_W   (PERIOD_W),
        .DUR_W      (DUR_W),
        .TICK_DIV   (TICK_DIV),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .note_val         (note_val),
        .note_rdy         (note_rdy),
        .note_half_period (note_half_period),
        .note_dur         (note_dur),
        .stop             (stop),
        .audio_out        (audio_out),
        .busy             (busy),
        .done             (done)
    );

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Expected PLAY cycles: high for hp cycles, low for hp cycles, repeating; silent for a rest.
    task automatic push_play(input int hp, input int cycles);
        exp_t e;
        for (int i = 0; i < cycles; i++) begin
            e.audio = (hp == 0) ? 1'b0 : (((i / hp) % 2) == 0);
            e.busy  = 1'b1;
            e.done  = 1'b0;
            e.rdy   = 1'b0;
            sb.push_back(e);
        end
    endtask

    task automatic push_tail();
        for (int i = 0; i < GAP_CYCLES; i++)
            sb.push_back('{audio: 1'b0, busy: 1'b1, done: 1'b0, rdy: 1'b0});
        sb.push_back('{audio: 1'b0, busy: 1'b0, done: 1'b1, rdy: 1'b0});
    endtask

    task automatic apply_stimulus(input int hp, input int dur);
        note_half_period = PERIOD_W'(hp);
        note_dur         = DUR_W'(dur);
        note_val         = 1'b1;
        @(posedge clk) #1;
        note_val = 1'b0;
        check_output("busy_after_accept", busy, 1'b1);
    endtask

    task automatic wait_idle(input string name);
        int k;
        for (k = 0; k < 200; k++) begin
            @(posedge clk) #1;
            if (sb.size() == 0 && !busy && !done)
                break;
        end
        if (k == 200) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL %s: timeout, queue holds %0d, expected 0", name, sb.size());
        end
    endtask

    // Monitor: every cycle the DUT is busy or signalling done must match the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && (busy || done)) begin
                if (sb.size() == 0) begin
                    check_output("unexpected_activity", {audio_out, busy, done, note_rdy}, 4'b0000);
                end else begin
                    e = sb.pop_front();
                    check_output("trace", {audio_out, busy, done, note_rdy}, e);
                end
            end
        end
    end

    initial begin
        int k;
        rst = 1'b0;
        note_val = 1'b0;
        note_half_period = '0;
        note_dur = '0;
        stop = 1'b0;

        #2;
        check_output("reset_audio", audio_out, 1'b0);
        check_output("reset_busy", busy, 1'b0);
        check_output("reset_done", done, 1'b0);
        #10 rst = 1'b1;
        @(posedge clk) #1;
        check_output("idle_rdy", note_rdy, 1'b1);

        $display("[TB] basic note hp=3 dur=2");
        push_play(3, 8);
        push_tail();
        apply_stimulus(3, 2);
        wait_idle("basic");
        check_output("rdy_after_done", note_rdy, 1'b1);

        $display("[TB] rest hp=0 dur=1");
        push_play(0, 4);
        push_tail();
        apply_stimulus(0, 1);
        wait_idle("rest");

        $display("[TB] zero duration");
        push_tail();
        apply_stimulus(5, 0);
        wait_idle("zero_dur");

        $display("[TB] held valid across two notes");
        push_play(1, 4);
        push_tail();
        push_play(2, 4);
        push_tail();
        note_half_period = 8'd1;
        note_dur = 8'd1;
        note_val = 1'b1;
        @(posedge clk) #1;
        note_half_period = 8'd2;
        for (k = 0; k < 50; k++) begin
            @(posedge clk) #1;
            if (done) break;
        end
        check_output("first_done_seen", done, 1'b1);
        @(posedge clk) #1;
        check_output("gap_cycle_idle_busy", busy, 1'b0);
        check_output("gap_cycle_idle_rdy", note_rdy, 1'b1);
        @(posedge clk) #1;
        note_val = 1'b0;
        check_output("second_accepted", busy, 1'b1);
        wait_idle("back_to_back");

        $display("[TB] stop mid-note");
        push_play(2, 5);
        apply_stimulus(2, 3);
        repeat (4) @(posedge clk) #1;
        stop = 1'b1;
        @(posedge clk) #1;
        check_output("stop_audio", audio_out, 1'b0);
        check_output("stop_busy", busy, 1'b0);
        check_output("stop_done", done, 1'b0);
        check_output("stop_blocks_rdy", note_rdy, 1'b0);
        stop = 1'b0;
        #1;
        check_output("rdy_after_stop", note_rdy, 1'b1);
        repeat (4) @(posedge clk) #1;
        check_output("stop_queue_empty", sb.size(), 0);

        $display("[TB] async reset mid-note");
        push_play(1, 2);
        apply_stimulus(1, 4);
        repeat (2) @(posedge clk) #1;
        check_output("pre_reset_audio", audio_out, 1'b1);
        #1 rst = 1'b0;
        #1;
        check_output("async_reset_audio", audio_out, 1'b0);
        check_output("async_reset_busy", busy, 1'b0);
        #4 rst = 1'b1;
        @(posedge clk) #1;
        check_output("rdy_after_reset", note_rdy, 1'b1);
        push_play(1, 16);
        push_tail();
        apply_stimulus(1, 4);
        wait_idle("fresh_note");

        repeat (3) @(posedge clk) #1;
        check_output("final_queue_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/note_player.md
Name: note_player

Overview:
- Consumer end of the music player's note stream: accepts one note at a time from the song sequencer over a valid/ready handshake.
- Plays the note as a square wave on a 1-bit audio output for a programmed duration.
- Inserts a fixed silent gap after each note, then pulses `done`.
- Sits between the song sequencer (producer) and the speaker/PWM pin.

Parameters:
- PERIOD_W, 16: width of the half-period field, in clock cycles.
- DUR_W, 16: width of the duration field, in ticks.
- TICK_DIV, 1000: clock cycles per duration tick; must be >= 1.
- GAP_CYCLES, 0: silent cycles inserted after every note; 0 means no gap.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- note_val  input  1  producer presents a valid note.
- note_rdy  output  1  block can accept a note.
- note_half_period  input  PERIOD_W  tone half-period in cycles; 0 means a rest (silence).
- note_dur  input  DUR_W  note length in ticks.
- stop  input  1  synchronous abort of the current note or gap.
- audio_out  output  1  square-wave output.
- busy  output  1  high in PLAY or GAP.
- done  output  1  one-cycle pulse when a note (including its gap) completes.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; audio_out=0; done=0; busy=0; all counters 0. Consequently note_rdy=1.
- note_rdy = (state==IDLE) && !stop. This is combinational from state and stop; there is no other combinational path from inputs.
- Accept occurs on a rising edge with note_val && note_rdy.
  - Latch hp=note_half_period and rem=note_dur.
  - Clear the phase and tick counters.
- Accept with dur!=0: go to PLAY. In the first PLAY cycle audio_out=1 if hp!=0, else 0.
- Accept with dur==0: skip PLAY. Go to GAP if GAP_CYCLES>0, otherwise go to DONE.
- PLAY, tone:
  - Phase counter runs 0..hp-1.
  - On the cycle it equals hp-1, audio_out toggles and the counter wraps to 0.
  - Output period is 2*hp cycles. hp=1 toggles every cycle.
  - hp=0 holds audio_out=0 for the whole note.
- PLAY, duration:
  - Tick counter runs 0..TICK_DIV-1; at TICK_DIV-1, rem decrements.
  - When rem==1 and the tick fires: leave PLAY and force audio_out=0 on the next cycle.
  - Next state is GAP, or DONE if GAP_CYCLES==0.
  - PLAY therefore lasts exactly dur*TICK_DIV cycles.
- GAP: audio_out=0 for exactly GAP_CYCLES cycles, then DONE.
- DONE: a single cycle with done=1, audio_out=0, busy=0; then IDLE.
  - note_rdy is 0 during DONE, so back-to-back notes are spaced by at least one cycle.
- stop=1 in PLAY, GAP or DONE: IDLE on the next edge; audio_out=0 and no done pulse.
  - stop=1 in IDLE blocks acceptance; state stays IDLE.
  - stop has priority over a simultaneous tick or end-of-note.
- note_val while not ready is ignored. Input fields are sampled only at accept; changes during PLAY have no effect.
- Asynchronous reset mid-note: audio_out goes to 0 immediately, without waiting for a clock edge; no done pulse.
- Counter widths:
  - phase counter: PERIOD_W
  - rem: DUR_W
  - tick counter: clog2(TICK_DIV), minimum 1 bit
  - gap counter: clog2(GAP_CYCLES+1)
  - no counter may overflow for any legal parameter value.

Decomposition:
- Package note_player_pkg:
  - state enum: IDLE, PLAY, GAP, DONE
  - localparam helper for counter widths
- One sub-module, note_tone_gen:
  - ports: clk, rst, en, hp, audio
  - holds the phase counter and toggle flop
  - clears to audio=0 when en=0
  - starts audio=1 on the first enabled cycle when hp!=0
- The top level contains the FSM, the tick prescaler, the rem counter and the gap counter.

Test Plan (bench params: TICK_DIV=4, GAP_CYCLES=2, PERIOD_W=8, DUR_W=8):
- Reset then idle: rst=0 -> audio_out=0, busy=0, done=0. Release rst -> note_rdy=1.
- Basic note: hp=3, dur=2, one-cycle val.
  - busy=1 for 8 PLAY cycles plus 2 GAP cycles.
  - audio_out pattern over PLAY is 1,1,1,0,0,0,1,1; then 0 during GAP.
  - done=1 exactly one cycle after the gap; note_rdy=1 the cycle after that.
- Rest and zero-duration:
  - hp=0, dur=1 -> audio_out=0 throughout, 4 PLAY + 2 GAP cycles, then a done pulse.
  - dur=0 -> no PLAY cycles, 2 GAP cycles, then a done pulse.
- Handshake:
  - Hold val=1 across two queued notes (hp=1,dur=1 then hp=2,dur=1) -> second accepted only on the cycle after done.
  - While busy, note_rdy=0 and input changes do not alter audio_out.
- Stop mid-note: hp=2, dur=3, assert stop in PLAY cycle 5 -> next cycle audio_out=0, busy=0, no done pulse, note_rdy=1 once stop drops.
- Async reset mid-note: hp=1, dur=4, drop rst between edges in PLAY cycle 3 -> audio_out=0 immediately. After release, a fresh note plays its full 16 PLAY cycles.
